// File: rtl/prod_accum_if.sv
// Product-stream accumulator bundle: job control, product beat handshake, result handshake.
// slave = accumulator side, master = the producer/consumer driving it.
interface prod_accum_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int LEN_WIDTH = 8
) ();
    logic                 start;
    logic [LEN_WIDTH-1:0] len_in;
    logic [WIDTH-1:0]     prod_in;
    logic                 prod_valid;
    logic                 prod_ready;
    logic [ACC_WIDTH-1:0] sum_out;
    logic                 sum_valid;
    logic                 sum_ready;
    logic                 busy;
    logic                 overflow;

    modport slave (
        input  start, len_in, prod_in, prod_valid, sum_ready,
        output prod_ready, sum_out, sum_valid, busy, overflow
    );

    modport master (
        output start, len_in, prod_in, prod_valid, sum_ready,
        input  prod_ready, sum_out, sum_valid, busy, overflow
    );
endinterface

// File: rtl/prod_accum.sv
// Sums a programmed count of products; sum_valid the cycle after the last beat (len=N: N+1 cycles after start).
// Upstream stalls via prod_valid; result is held in DONE until sum_ready, input is not accepted meanwhile.
module prod_accum #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int LEN_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    prod_accum_if.slave  io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ACC_WIDTH-1:0] acc;
    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [ACC_WIDTH-1:0] sum_q;
    logic                 ovf_q;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   add_full;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic                 beat_acc;
    logic                 last_beat;
    logic                 start_acc;
    logic                 len_zero;

    assign prod_ext  = ACC_WIDTH'(io.prod_in);
    // One extra bit captures the carry out of the accumulator MSB.
    assign add_full  = {1'b0, acc} + {1'b0, prod_ext};
    assign cnt_inc   = cnt + LEN_WIDTH'(1);
    assign beat_acc  = (state == ACCUM) && io.prod_valid;
    assign last_beat = (cnt_inc == len_q);
    assign start_acc = (state == IDLE) && io.start;
    assign len_zero  = (io.len_in == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (io.start) begin
                    state_nxt = len_zero ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (io.prod_valid && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (io.sum_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (start_acc) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= io.len_in;
            ovf_q <= 1'b0;
            if (len_zero) begin
                sum_q <= '0;
            end
        end else if (beat_acc) begin
            acc <= add_full[ACC_WIDTH-1:0];
            cnt <= cnt_inc;
            if (add_full[ACC_WIDTH]) begin
                ovf_q <= 1'b1;
            end
            if (last_beat) begin
                sum_q <= add_full[ACC_WIDTH-1:0];
            end
        end
    end

    assign io.prod_ready = (state == ACCUM);
    assign io.sum_valid  = (state == DONE);
    assign io.busy       = (state != IDLE);
    assign io.sum_out    = sum_q;
    assign io.overflow   = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a 40-bit accumulator instance plus a 16-bit one for the wrap case.
`timescale 1ns/1ps
module tb_prod_accum;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    prod_accum_if #(.WIDTH(16), .ACC_WIDTH(40), .LEN_WIDTH(8)) bus ();
    prod_accum_if #(.WIDTH(16), .ACC_WIDTH(16), .LEN_WIDTH(8)) bus16 ();

    prod_accum #(.WIDTH(16), .ACC_WIDTH(40), .LEN_WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    prod_accum #(.WIDTH(16), .ACC_WIDTH(16), .LEN_WIDTH(8)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .io  (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [63:0] exp_sum);
        chk({tag, ".busy"},  bus.busy,       1'b0);
        chk({tag, ".prdy"},  bus.prod_ready, 1'b0);
        chk({tag, ".svld"},  bus.sum_valid,  1'b0);
        chk({tag, ".sum"},   bus.sum_out,    exp_sum);
    endtask

    logic [15:0] basic_v [4];
    logic [15:0] stall_v [3];

    initial begin
        n_chk = 0;
        n_bad = 0;
        basic_v = '{16'd3, 16'd5, 16'd7, 16'd9};
        stall_v = '{16'd100, 16'd200, 16'd300};

        rst = 1'b1;
        bus.start = 1'b0;   bus.len_in = '0;   bus.prod_in = '0;
        bus.prod_valid = 1'b0; bus.sum_ready = 1'b0;
        bus16.start = 1'b0; bus16.len_in = '0; bus16.prod_in = '0;
        bus16.prod_valid = 1'b0; bus16.sum_ready = 1'b1;
        #12;
        chk_idle("rst", 0);
        chk("rst.ovf", bus.overflow, 1'b0);
        rst = 1'b0;
        tick();

        // Basic job: 3+5+7+9 = 24, sum_valid one cycle only.
        bus.sum_ready = 1'b1;
        bus.start = 1'b1; bus.len_in = 8'd4;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("basic.prdy", bus.prod_ready, 1'b1);
            chk("basic.svld_early", bus.sum_valid, 1'b0);
            bus.prod_valid = 1'b1; bus.prod_in = basic_v[i];
            tick();
        end
        bus.prod_valid = 1'b0;
        chk("basic.svld", bus.sum_valid, 1'b1);
        chk("basic.sum",  bus.sum_out,   24);
        chk("basic.ovf",  bus.overflow,  1'b0);
        chk("basic.prdy_done", bus.prod_ready, 1'b0);
        tick();
        chk_idle("basic.end", 24);

        // Stalled input and output: 100+200+300 = 600.
        bus.sum_ready = 1'b0;
        bus.start = 1'b1; bus.len_in = 8'd3;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.prod_valid = 1'b1; bus.prod_in = stall_v[i];
            tick();
            bus.prod_valid = 1'b0; bus.prod_in = 16'hBEEF;
            if (i < 2) begin
                for (int k = 0; k < 2; k++) begin
                    chk("stall.prdy_gap", bus.prod_ready, 1'b1);
                    chk("stall.svld_gap", bus.sum_valid, 1'b0);
                    tick();
                end
            end
        end
        chk("stall.prdy_done", bus.prod_ready, 1'b0);
        bus.prod_valid = 1'b1; bus.prod_in = 16'd999;
        for (int k = 0; k < 4; k++) begin
            chk("stall.svld_hold", bus.sum_valid, 1'b1);
            chk("stall.sum_hold",  bus.sum_out,   600);
            tick();
        end
        bus.prod_valid = 1'b0;
        chk("stall.svld_last", bus.sum_valid, 1'b1);
        bus.sum_ready = 1'b1;
        tick();
        chk_idle("stall.end", 600);

        // Zero length: straight to DONE with sum 0; a pending beat is never taken.
        bus.start = 1'b1; bus.len_in = 8'd0;
        bus.prod_valid = 1'b1; bus.prod_in = 16'd77;
        tick();
        bus.start = 1'b0;
        chk("zero.prdy", bus.prod_ready, 1'b0);
        chk("zero.svld", bus.sum_valid,  1'b1);
        chk("zero.sum",  bus.sum_out,    0);
        tick();
        bus.prod_valid = 1'b0;
        chk_idle("zero.end", 0);

        // Overflow wrap on the 16-bit accumulator: FFFF + 2 = 0x1 with carry.
        bus16.start = 1'b1; bus16.len_in = 8'd2;
        tick();
        bus16.start = 1'b0;
        bus16.prod_valid = 1'b1; bus16.prod_in = 16'hFFFF;
        tick();
        chk("ovf.mid_svld", bus16.sum_valid, 1'b0);
        bus16.prod_in = 16'h0002;
        tick();
        bus16.prod_valid = 1'b0;
        chk("ovf.svld", bus16.sum_valid, 1'b1);
        chk("ovf.sum",  bus16.sum_out,   16'h0001);
        chk("ovf.flag", bus16.overflow,  1'b1);
        tick();
        chk("ovf.sticky", bus16.overflow, 1'b1);
        bus16.start = 1'b1; bus16.len_in = 8'd1;
        tick();
        bus16.start = 1'b0;
        chk("ovf.clear", bus16.overflow, 1'b0);
        bus16.prod_valid = 1'b1; bus16.prod_in = 16'd5;
        tick();
        bus16.prod_valid = 1'b0;
        chk("ovf.sum2",  bus16.sum_out,  16'd5);
        chk("ovf.flag2", bus16.overflow, 1'b0);
        tick();

        // Start pulsed mid-job must not shorten, restart or clear the job: 10+20+30 = 60.
        bus.start = 1'b1; bus.len_in = 8'd3;
        tick();
        bus.start = 1'b0;
        bus.prod_valid = 1'b1; bus.prod_in = 16'd10;
        tick();
        bus.prod_valid = 1'b0;
        bus.start = 1'b1; bus.len_in = 8'd1;
        tick();
        bus.start = 1'b0; bus.len_in = 8'd0;
        chk("ign.busy", bus.busy, 1'b1);
        bus.prod_valid = 1'b1; bus.prod_in = 16'd20;
        tick();
        chk("ign.svld_early", bus.sum_valid, 1'b0);
        bus.prod_in = 16'd30;
        tick();
        bus.prod_valid = 1'b0;
        chk("ign.svld", bus.sum_valid, 1'b1);
        chk("ign.sum",  bus.sum_out,   60);
        tick();
        chk_idle("ign.end", 60);

        // Asynchronous reset between edges after 2 of 5 beats.
        bus.start = 1'b1; bus.len_in = 8'd5;
        tick();
        bus.start = 1'b0;
        bus.prod_valid = 1'b1; bus.prod_in = 16'd1;
        tick();
        bus.prod_in = 16'd2;
        tick();
        chk("arst.pre_busy", bus.busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("arst", 0);
        chk("arst.ovf", bus.overflow, 1'b0);
        bus.prod_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        chk_idle("arst.after", 0);
        bus.start = 1'b1; bus.len_in = 8'd1;
        tick();
        bus.start = 1'b0;
        bus.prod_valid = 1'b1; bus.prod_in = 16'd42;
        tick();
        bus.prod_valid = 1'b0;
        chk("fresh.svld", bus.sum_valid, 1'b1);
        chk("fresh.sum",  bus.sum_out,   42);
        tick();
        chk_idle("fresh.end", 42);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream consumer of the registered-input multiplier stage: takes its WIDTH-bit unsigned product stream and accumulates a programmed number of products into a wide sum (dot-product / MAC tail).
- Upstream side uses a valid/ready beat handshake; the result is offered on a valid/ready output port.
- A small FSM sequences each job: start, accumulate N beats, hold result until taken.

Parameters:
WIDTH, 16, bit width of each incoming product (matches multiplier output width)
ACC_WIDTH, 40, accumulator and result width; must be >= WIDTH
LEN_WIDTH, 8, width of the beat-count field; max job length 2^LEN_WIDTH-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle job start request; honoured only in IDLE
len_in  input  LEN_WIDTH  number of products in the job, sampled with start
prod_in  input  WIDTH  unsigned product data
prod_valid  input  1  prod_in holds a valid beat
prod_ready  output  1  block accepts a beat this cycle
sum_out  output  ACC_WIDTH  accumulated result
sum_valid  output  1  sum_out holds a completed result
sum_ready  input  1  downstream takes the result
busy  output  1  high in any state other than IDLE
overflow  output  1  sticky: accumulator wrapped during the current or last job

Behaviour:
- Reset (asynchronous, active-high) forces state=IDLE, accumulator=0, beat count=0, sum_out=0, sum_valid=0, prod_ready=0, busy=0, overflow=0. Reset mid-job abandons the job with no result.
- States: IDLE, ACCUM, DONE. All outputs are registered or decoded only from state.
- IDLE: prod_ready=0. start=1 latches len_in, clears the accumulator, count and overflow.
  - len_in!=0 -> ACCUM next cycle.
  - len_in==0 -> DONE next cycle with sum_out=0.
- ACCUM: prod_ready=1. A beat is accepted when prod_valid && prod_ready.
  - Each accepted beat adds prod_in zero-extended to ACC_WIDTH to the accumulator, modulo 2^ACC_WIDTH, and increments the count.
  - A carry out of bit ACC_WIDTH-1 sets overflow, which stays set until the next accepted start.
  - prod_valid=0 cycles stall and leave the accumulator and count unchanged.
  - On acceptance of beat number len: the final sum (including that beat) is loaded into sum_out and the FSM goes to DONE. sum_valid rises the cycle after the last beat is accepted.
- DONE: prod_ready=0, sum_valid=1, and sum_out held stable until sum_ready=1. On sum_valid && sum_ready: sum_valid=0 next cycle and the FSM goes to IDLE.
  - With sum_ready tied high, DONE lasts exactly one cycle.
- start outside IDLE is ignored, with no effect on the job, len or overflow. start in the same cycle the FSM enters IDLE is sampled normally on the next edge only if still asserted.
- sum_out keeps the last result in IDLE until the next job completes; it is not cleared by start.
- prod_in is ignored whenever prod_ready=0, even if prod_valid=1. Upstream must hold prod_in/prod_valid until accepted.
- Latency, len=N with prod_valid held high: start at cycle 0, beats accepted at cycles 1..N, sum_valid at cycle N+1.

Test Plan:
- Basic job: reset, start with len=4, products 3,5,7,9 back-to-back with prod_valid=1 and sum_ready=1 -> sum_out=24, sum_valid high for exactly 1 cycle at cycle 5, overflow=0, busy low again at cycle 6.
- Stalled input and output: len=3, products 100,200,300 with 2 idle cycles between beats, sum_ready low for 4 cycles -> prod_ready drops after the 3rd beat, sum_out=600 held stable through the backpressure, then IDLE one cycle after sum_ready=1.
- Zero length: start with len=0 -> no beats accepted (prod_ready stays 0), sum_valid=1 with sum_out=0 one cycle after start.
- Overflow wrap: ACC_WIDTH=WIDTH=16, len=2, products 0xFFFF and 0x0002 -> sum_out=0x0001, overflow=1; the next start clears overflow to 0.
- Ignored start: during ACCUM of a len=3 job, pulse start with len_in=1 -> job still consumes 3 beats and reports the correct sum; the len=1 request has no effect.
- Async reset mid-job: assert rst between clock edges after 2 of 5 beats -> all outputs go to reset values immediately without waiting for a clock edge. After release, a fresh len=1 job with product 42 -> sum_out=42.
